casez_select_checker: RTL and testbench

- Pipelined, sequential consumer of the unique-casez select decode used in the V3Assert isolation suite.
- Registers the 4-bit select key and evaluates all five casez patterns in parallel.
- Produces the priority (first-match) result code and flags unique-case violations: overlap (more than one pattern matches) and no-match.
- Keeps armed, saturating violation counters and a first-violation capture, used as a self-checking monitor beside the decode stage.

---
 rtl/casez_select_checker.sv | 165 ++++++++++++++++
 tb/tb_casez_select_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/casez_select_checker.sv
// Two-stage unique-casez select decoder with an armed violation monitor:
// overlap / no-match flags, saturating counters and first-violation capture.
module casez_select_checker #(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       case_expr,
  input  logic [3:0]       case_inside_val,
  input  logic             arm,
  input  logic             clr,
  output logic             out_valid,
  output logic [4:0]       internal_out,
  output logic [4:0]       match_vec,
  output logic             viol_overlap,
  output logic             viol_none,
  output logic [CNT_W-1:0] overlap_cnt,
  output logic [CNT_W-1:0] none_cnt,
  output logic [1:0]       state,
  output logic [3:0]       first_key,
  output logic [1:0]       first_kind
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } state_e;

  localparam logic [1:0] KIND_OVERLAP = 2'b01;
  localparam logic [1:0] KIND_NONE    = 2'b10;

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_key_q, s1_key_d;
  logic             out_valid_q, out_valid_d;
  logic [4:0]       internal_out_q, internal_out_d;
  logic [4:0]       match_vec_q, match_vec_d;
  logic             viol_overlap_q, viol_overlap_d;
  logic             viol_none_q, viol_none_d;
  logic [CNT_W-1:0] overlap_cnt_q, overlap_cnt_d;
  logic [CNT_W-1:0] none_cnt_q, none_cnt_d;
  logic [3:0]       first_key_q, first_key_d;
  logic [1:0]       first_kind_q, first_kind_d;
  state_e           state_q, state_d;

  logic             any_viol;
  logic             counting;

  // Stage 1: build and register the select key.
  always_comb begin
    s1_valid_d = in_valid;
    s1_key_d   = {case_expr[0], case_inside_val[3], case_inside_val[2], case_expr[1]};
  end

  // Stage 2: all patterns in parallel, plus first-match priority code.
  always_comb begin
    match_vec_d[0] = (s1_key_q ==? 4'b1?0?);
    match_vec_d[1] = (s1_key_q ==? 4'b?101);
    match_vec_d[2] = (s1_key_q ==? 4'b0?1?);
    match_vec_d[3] = (s1_key_q ==? 4'b1?1?);
    match_vec_d[4] = (s1_key_q ==? 4'b?111);

    // NOTE: every comb output gets a default before the case so no latch is inferred.
    internal_out_d = 5'd0;
    casez (s1_key_q)
      4'b1?0?: internal_out_d = 5'd30;
      4'b?101: internal_out_d = 5'd31;
      4'b0?1?: internal_out_d = 5'd32;
      4'b1?1?: internal_out_d = 5'd33;
      4'b?111: internal_out_d = 5'd34;
      default: internal_out_d = 5'd0;
    endcase

    out_valid_d    = s1_valid_q;
    viol_overlap_d = s1_valid_q && ($countones(match_vec_d) > 1);
    viol_none_d    = s1_valid_q && (match_vec_d == 5'd0);
  end

  assign any_viol = viol_overlap_d | viol_none_d;
  assign counting = (state_q == ARMED);

  // Next-state logic; clr dominates everything, arm only matters in IDLE.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED:   if (any_viol && STOP_ON_ERR) state_d = TRIPPED;
        TRIPPED: state_d = TRIPPED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters and capture track the violation registering on this same edge.
  always_comb begin
    overlap_cnt_d = overlap_cnt_q;
    none_cnt_d    = none_cnt_q;
    first_key_d   = first_key_q;
    first_kind_d  = first_kind_q;
    if (clr) begin
      overlap_cnt_d = '0;
      none_cnt_d    = '0;
      first_key_d   = 4'd0;
      first_kind_d  = 2'b00;
    end else if (counting) begin
      if (viol_overlap_d && (overlap_cnt_q != '1)) overlap_cnt_d = overlap_cnt_q + 1'b1;
      if (viol_none_d && (none_cnt_q != '1))       none_cnt_d    = none_cnt_q + 1'b1;
      if (any_viol && (first_kind_q == 2'b00)) begin
        first_key_d  = s1_key_q;
        first_kind_d = viol_overlap_d ? KIND_OVERLAP : KIND_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_key_q       <= 4'd0;
      out_valid_q    <= 1'b0;
      internal_out_q <= 5'd0;
      match_vec_q    <= 5'd0;
      viol_overlap_q <= 1'b0;
      viol_none_q    <= 1'b0;
      overlap_cnt_q  <= '0;
      none_cnt_q     <= '0;
      first_key_q    <= 4'd0;
      first_kind_q   <= 2'b00;
      state_q        <= IDLE;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_key_q       <= s1_key_d;
      out_valid_q    <= out_valid_d;
      internal_out_q <= internal_out_d;
      match_vec_q    <= match_vec_d;
      viol_overlap_q <= viol_overlap_d;
      viol_none_q    <= viol_none_d;
      overlap_cnt_q  <= overlap_cnt_d;
      none_cnt_q     <= none_cnt_d;
      first_key_q    <= first_key_d;
      first_kind_q   <= first_kind_d;
      state_q        <= state_d;
    end
  end

  always_comb begin
    state = state_q;
  end

  assign out_valid    = out_valid_q;
  assign internal_out = internal_out_q;
  assign match_vec    = match_vec_q;
  assign viol_overlap = viol_overlap_q;
  assign viol_none    = viol_none_q;
  assign overlap_cnt  = overlap_cnt_q;
  assign none_cnt     = none_cnt_q;
  assign first_key    = first_key_q;
  assign first_kind   = first_kind_q;

endmodule

// File: tb/tb_casez_select_checker.sv
// Scoreboard bench for casez_select_checker: one instance per STOP_ON_ERR setting,
// sharing stimulus; decode results are checked by a monitor as they emerge.
module tb_casez_select_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] case_expr = 2'd0;
  logic [3:0] case_inside_val = 4'd0;
  logic       arm = 1'b0;
  logic       clr = 1'b0;

  // a_* : STOP_ON_ERR = 1, b_* : STOP_ON_ERR = 0
  logic       a_out_valid, b_out_valid;
  logic [4:0] a_internal_out, b_internal_out;
  logic [4:0] a_match_vec, b_match_vec;
  logic       a_viol_overlap, b_viol_overlap;
  logic       a_viol_none, b_viol_none;
  logic [7:0] a_overlap_cnt, b_overlap_cnt;
  logic [7:0] a_none_cnt, b_none_cnt;
  logic [1:0] a_state, b_state;
  logic [3:0] a_first_key, b_first_key;
  logic [1:0] a_first_kind, b_first_kind;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0] code;
    logic [4:0] mvec;
    logic       ov;
    logic       nm;
  } exp_t;

  exp_t exp_q[$];

  casez_select_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .case_expr(case_expr),
    .case_inside_val(case_inside_val), .arm(arm), .clr(clr),
    .out_valid(a_out_valid), .internal_out(a_internal_out), .match_vec(a_match_vec),
    .viol_overlap(a_viol_overlap), .viol_none(a_viol_none),
    .overlap_cnt(a_overlap_cnt), .none_cnt(a_none_cnt), .state(a_state),
    .first_key(a_first_key), .first_kind(a_first_kind)
  );

  casez_select_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) u_cont (
    .clk(clk), .rst(rst), .in_valid(in_valid), .case_expr(case_expr),
    .case_inside_val(case_inside_val), .arm(arm), .clr(clr),
    .out_valid(b_out_valid), .internal_out(b_internal_out), .match_vec(b_match_vec),
    .viol_overlap(b_viol_overlap), .viol_none(b_viol_none),
    .overlap_cnt(b_overlap_cnt), .none_cnt(b_none_cnt), .state(b_state),
    .first_key(b_first_key), .first_kind(b_first_kind)
  );

  always #5 clk = ~clk;

  wire [23:0] a_st  = {a_state, a_overlap_cnt, a_none_cnt, a_first_key, a_first_kind};
  wire [23:0] b_st  = {b_state, b_overlap_cnt, b_none_cnt, b_first_key, b_first_kind};
  wire [12:0] a_dat = {a_out_valid, a_internal_out, a_match_vec, a_viol_overlap, a_viol_none};
  wire [12:0] b_dat = {b_out_valid, b_internal_out, b_match_vec, b_viol_overlap, b_viol_none};

  // Reference decode written from the pattern table bit by bit.
  function automatic exp_t model(input logic [3:0] k);
    exp_t e;
    e.mvec[0] = k[3] & ~k[1];
    e.mvec[1] = k[2] & ~k[1] & k[0];
    e.mvec[2] = ~k[3] & k[1];
    e.mvec[3] = k[3] & k[1];
    e.mvec[4] = k[2] & k[1] & k[0];
    if      (e.mvec[0]) e.code = 5'd30;
    else if (e.mvec[1]) e.code = 5'd31;
    else if (e.mvec[2]) e.code = 5'd32;
    else if (e.mvec[3]) e.code = 5'd33;
    else if (e.mvec[4]) e.code = 5'd34;
    else                e.code = 5'd0;
    e.ov = ($countones(e.mvec) > 1);
    e.nm = (e.mvec == 5'd0);
    return e;
  endfunction

  // Drive one cycle of stimulus; key bits map back onto the two operands.
  task automatic cycle(input logic [3:0] k, input logic v, input logic a, input logic c);
    logic [1:0] junk;
    junk            = 2'($urandom_range(0, 3));
    case_expr       = {k[0], k[3]};
    case_inside_val = {k[2], k[1], junk};
    in_valid        = v;
    arm             = a;
    clr             = c;
    if (v) exp_q.push_back(model(k));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    arm      = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every valid output pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (a_out_valid || b_out_valid)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: out_valid a=%b b=%b with empty queue at %0t",
                 a_out_valid, b_out_valid, $time);
      end else begin
        e = exp_q.pop_front();
        if (a_dat !== {1'b1, e.code, e.mvec, e.ov, e.nm}) begin
          errors++;
          $display("FAIL sb_stop: got %h expected %h at %0t", a_dat,
                   {1'b1, e.code, e.mvec, e.ov, e.nm}, $time);
        end
        checks++;
        if (b_dat !== {1'b1, e.code, e.mvec, e.ov, e.nm}) begin
          errors++;
          $display("FAIL sb_cont: got %h expected %h at %0t", b_dat,
                   {1'b1, e.code, e.mvec, e.ov, e.nm}, $time);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    checks++;
    if ({a_dat, a_st} !== 37'd0) begin
      errors++;
      $display("FAIL reset_stop: got %h expected 0", {a_dat, a_st});
    end
    checks++;
    if ({b_dat, b_st} !== 37'd0) begin
      errors++;
      $display("FAIL reset_cont: got %h expected 0", {b_dat, b_st});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    cycle(4'd0, 1'b0, 1'b1, 1'b0);
    cycle(4'b0110, 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid got %b expected 0", a_out_valid);
    end
    cycle(4'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({a_out_valid, a_internal_out} !== {1'b1, 5'd32}) begin
      errors++;
      $display("FAIL latency_two: got %b/%0d expected 1/32", a_out_valid, a_internal_out);
    end
    idle(2);
    checks++;
    if (a_st !== {2'd1, 8'd0, 8'd0, 4'h0, 2'b00}) begin
      errors++;
      $display("FAIL basic_stop_status: got %h expected %h", a_st, {2'd1, 8'd0, 8'd0, 4'h0, 2'b00});
    end
    checks++;
    if (b_st !== {2'd1, 8'd0, 8'd0, 4'h0, 2'b00}) begin
      errors++;
      $display("FAIL basic_cont_status: got %h expected %h", b_st, {2'd1, 8'd0, 8'd0, 4'h0, 2'b00});
    end
  endtask

  task automatic test_stop_on_err;
    cycle(4'b1101, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    idle(2);
    checks++;
    if (a_st !== {2'd2, 8'd1, 8'd0, 4'b1101, 2'b01}) begin
      errors++;
      $display("FAIL stop_trip: got %h expected %h", a_st, {2'd2, 8'd1, 8'd0, 4'b1101, 2'b01});
    end
    checks++;
    if (b_st !== {2'd1, 8'd1, 8'd1, 4'b1101, 2'b01}) begin
      errors++;
      $display("FAIL stop_cont_counts: got %h expected %h", b_st, {2'd1, 8'd1, 8'd1, 4'b1101, 2'b01});
    end
  endtask

  task automatic test_continue;
    cycle(4'd0, 1'b0, 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    cycle(4'b0111, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(4'b1010, 1'b1, 1'b0, 1'b0);
    idle(2);
    checks++;
    if (b_st !== {2'd1, 8'd2, 8'd1, 4'b0000, 2'b10}) begin
      errors++;
      $display("FAIL continue_cont: got %h expected %h", b_st, {2'd1, 8'd2, 8'd1, 4'b0000, 2'b10});
    end
    checks++;
    if (a_st !== {2'd2, 8'd0, 8'd1, 4'b0000, 2'b10}) begin
      errors++;
      $display("FAIL continue_stop: got %h expected %h", a_st, {2'd2, 8'd0, 8'd1, 4'b0000, 2'b10});
    end
  endtask

  task automatic test_saturation;
    cycle(4'd0, 1'b0, 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    idle(2);
    checks++;
    if (b_st !== {2'd1, 8'd255, 8'd0, 4'b1111, 2'b01}) begin
      errors++;
      $display("FAIL sat_cont: got %h expected %h", b_st, {2'd1, 8'd255, 8'd0, 4'b1111, 2'b01});
    end
    checks++;
    if (a_st !== {2'd2, 8'd1, 8'd0, 4'b1111, 2'b01}) begin
      errors++;
      $display("FAIL sat_stop: got %h expected %h", a_st, {2'd2, 8'd1, 8'd0, 4'b1111, 2'b01});
    end
    cycle(4'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({a_st, b_st} !== 48'd0) begin
      errors++;
      $display("FAIL clr_over_arm: got %h expected 0", {a_st, b_st});
    end
  endtask

  task automatic test_idle_counting;
    for (int i = 0; i < 5; i++) cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    idle(2);
    checks++;
    if ({a_st, b_st} !== 48'd0) begin
      errors++;
      $display("FAIL idle_no_count: got %h expected 0", {a_st, b_st});
    end
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(4'b0001, 1'b1, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (b_st !== {2'd1, 8'd0, 8'd1, 4'b0001, 2'b10}) begin
      errors++;
      $display("FAIL arm_same_edge_cont: got %h expected %h", b_st, {2'd1, 8'd0, 8'd1, 4'b0001, 2'b10});
    end
    checks++;
    if (a_st !== {2'd2, 8'd0, 8'd1, 4'b0001, 2'b10}) begin
      errors++;
      $display("FAIL arm_same_edge_stop: got %h expected %h", a_st, {2'd2, 8'd0, 8'd1, 4'b0001, 2'b10});
    end
  endtask

  task automatic test_reset_midstream;
    cycle(4'b0110, 1'b1, 1'b0, 1'b0);
    cycle(4'b1101, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(4'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({a_dat, a_st, b_dat, b_st} !== 74'd0) begin
        errors++;
        $display("FAIL reset_mid_%0d: got %h expected 0", i, {a_dat, a_st, b_dat, b_st});
      end
    end
    exp_q.delete();
    rst = 1'b0;
    cycle(4'b1010, 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early: out_valid got %b expected 0", a_out_valid);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop_on_err();
    test_continue();
    test_saturation();
    test_idle_counting();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results never appeared, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
